mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles Busy stays high for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: cycles Busy stays high for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  one-cycle launch of the operation on MD_Op; issued by the EX stage from the ID/EX register contents.
REQ-006 MD_Op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 D1  input  32  operand A / dividend / MTHI-MTLO source (forwarded rs value).
REQ-008 D2  input  32  operand B / divisor (forwarded rt value).
REQ-009 Busy  output  1  high while a multiply or divide is in flight.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 States: IDLE, MUL_RUN, DIV_RUN; internal down-counter CNT, internal operand/result latches.
REQ-013 IDLE, Start=1, MD_Op in {1,2}: latch D1/D2 and op, CNT<=MULT_CYCLES, go MUL_RUN.
REQ-014 IDLE, Start=1, MD_Op in {3,4}: latch D1/D2 and op, CNT<=DIV_CYCLES, go DIV_RUN.
REQ-015 MD_Op 5 (MTHI) or 6 (MTLO) shall write D1 into HI or LO on the same posedge; no Busy; Start is not required for MTHI/MTLO.
REQ-016 Busy shall be 1 in every cycle where state is MUL_RUN or DIV_RUN, 0 in IDLE; Busy is a registered output, rising the cycle after Start.
REQ-017 In a RUN state CNT decrements each cycle; on the edge where CNT==1 the unit writes HI/LO and returns to IDLE, so HI/LO hold new values exactly N cycles after the Start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-018 HI/LO shall hold their previous values for all cycles while Busy=1.
REQ-019 MULT: {HI,LO} = signed 64-bit product of D1 x D2; MULTU: unsigned 64-bit product.
REQ-020 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-021 DIV with D1=0x80000000, D2=0xFFFFFFFF shall give LO=0x80000000, HI=0x00000000.
REQ-022 Divide by zero (D2=0, DIV or DIVU): the operation runs full DIV_CYCLES with Busy, and HI/LO remain unchanged at completion.
REQ-023 Start, MTHI and MTLO shall be ignored while Busy=1 (upstream stalls); no state change, no HI/LO write.
REQ-024 Start with MD_Op in {0,5,6,7} shall not enter a RUN state; 5/6 still act per REQ-015.
REQ-025 Operands are taken only at the Start edge; D1/D2 changes during RUN shall not affect results.

Reset
REQ-026 reset=1 shall immediately (no clock needed) force state IDLE, CNT=0, Busy=0, HI=0x00000000, LO=0x00000000.
REQ-027 reset asserted mid-operation shall abort it; no result is written after reset deasserts.
REQ-028 First valid Start is accepted on the first posedge with reset=0.

Verification
REQ-029 MULT D1=0xFFFFFFFE (-2), D2=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV D1=0xFFFFFFF9 (-7), D2=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 MTHI D1=0x12345678 then MTLO D1=0x9ABCDEF0 in idle -> HI/LO updated next edge, Busy stays 0; DIVU by 0 afterwards -> HI/LO unchanged after 10 cycles.
REQ-032 Start MULT, then MTLO and a second Start DIV during Busy -> both ignored; only the MULT result appears.
REQ-033 Start DIV, assert reset asynchronously at cycle 4 -> Busy, HI, LO go 0 before the next edge; no write after release.
REQ-034 Back-to-back: Start MULT, Start DIV on the cycle Busy falls -> DIV accepted, second result 10 cycles later, HI/LO show MULT result in between.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Operands are latched at launch; the result is written when the down-counter expires.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MD_Op,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // state   | meaning
   // IDLE    | accepting Start and MTHI/MTLO
   // MUL_RUN | multiply in flight, Busy high
   // DIV_RUN | divide in flight, Busy high
   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               busy_q, busy_d;

   logic [63:0] mul_s, mul_u;
   logic [31:0] div_b, abs_a, abs_b, uq, ur, sq, sr;
   logic        b_zero;

   // Signed product = low 64 bits of the product of sign-extended operands.
   always_comb begin
      mul_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      mul_u = {32'd0, a_q} * {32'd0, b_q};
   end

   // Divisor forced non-zero so the datapath never divides by zero; the
   // divide-by-zero result is discarded at completion instead.
   always_comb begin
      b_zero = (b_q == 32'd0);
      div_b  = b_zero ? 32'd1 : b_q;
      abs_a  = (op_q == OP_DIV && a_q[31]) ? (~a_q + 32'd1) : a_q;
      abs_b  = (op_q == OP_DIV && div_b[31]) ? (~div_b + 32'd1) : div_b;
      uq     = abs_a / abs_b;
      ur     = abs_a % abs_b;
      sq     = (a_q[31] ^ div_b[31]) ? (~uq + 32'd1) : uq;
      sr     = a_q[31] ? (~ur + 32'd1) : ur;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (MD_Op == OP_MTHI) hi_d = D1;
            if (MD_Op == OP_MTLO) lo_d = D1;
            if (Start && (MD_Op == OP_MULT || MD_Op == OP_MULTU)) begin
               op_d    = MD_Op;
               a_d     = D1;
               b_d     = D2;
               cnt_d   = CNT_W'(MULT_CYCLES);
               state_d = MUL_RUN;
            end else if (Start && (MD_Op == OP_DIV || MD_Op == OP_DIVU)) begin
               op_d    = MD_Op;
               a_d     = D1;
               b_d     = D2;
               cnt_d   = CNT_W'(DIV_CYCLES);
               state_d = DIV_RUN;
            end
         end
         MUL_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (op_q == OP_MULT) {hi_d, lo_d} = mul_s;
               else                 {hi_d, lo_d} = mul_u;
            end
         end
         DIV_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!b_zero) begin
                  if (op_q == OP_DIV) begin
                     lo_d = sq;
                     hi_d = sr;
                  end else begin
                     lo_d = uq;
                     hi_d = ur;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: expected HI/LO pushed at launch,
// popped and compared when Busy drops.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Start = 1'b0;
   logic [2:0]  MD_Op = 3'd0;
   logic [31:0] D1 = 32'd0;
   logic [31:0] D2 = 32'd0;
   logic        Busy;
   logic [31:0] HI, LO;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MD_Op(MD_Op),
      .D1(D1), .D2(D2), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          passed = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model computed in 64-bit arithmetic.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi_in, input logic [31:0] lo_in,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
      longint sa, sb_, p, q, r;
      logic [63:0] ua, ub, up;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hi_o = hi_in;
      lo_o = lo_in;
      case (op)
         3'd1: begin p = sa * sb_; hi_o = p[63:32]; lo_o = p[31:0]; end
         3'd2: begin up = ua * ub; hi_o = up[63:32]; lo_o = up[31:0]; end
         3'd3: if (b != 0) begin q = sa / sb_; r = sa % sb_; lo_o = q[31:0]; hi_o = r[31:0]; end
         3'd4: if (b != 0) begin up = ua / ub; lo_o = up[31:0]; up = ua % ub; hi_o = up[31:0]; end
         default: ;
      endcase
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
      exp_t e;
      model(op, a, b, m_hi, m_lo, e.hi, e.lo);
      e.cycles = (op == 3'd1 || op == 3'd2) ? MC : DC;
      if (push) sb.push_back(e);
      Start = 1'b1;
      MD_Op = op;
      D1 = a;
      D2 = b;
      step();
      Start = 1'b0;
      MD_Op = 3'd0;
      D1 = $urandom;
      D2 = $urandom;
   endtask

   task automatic wait_done(input string tag, input int n);
      int   cnt;
      exp_t e;
      cnt = 0;
      while (Busy === 1'b1 && cnt < 50) begin
         chk({tag, "_hi_hold"}, HI, m_hi);
         chk({tag, "_lo_hold"}, LO, m_lo);
         cnt++;
         step();
      end
      chk({tag, "_busy_cycles"}, cnt, n);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_hi"}, HI, e.hi);
         chk({tag, "_lo"}, LO, e.lo);
         m_hi = e.hi;
         m_lo = e.lo;
      end
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      launch(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
      chk("mult_busy_rise", {31'd0, Busy}, 32'd1);
      wait_done("mult", MC);
      chk("mult_hi_const", HI, 32'hFFFFFFFF);
      chk("mult_lo_const", LO, 32'hFFFFFFFA);

      launch(3'd2, 32'hFFFFFFFE, 32'd3, 1'b1);
      wait_done("multu", MC);
      chk("multu_hi_const", HI, 32'h00000002);

      launch(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
      wait_done("div", DC);
      chk("div_lo_const", LO, 32'hFFFFFFFD);
      chk("div_hi_const", HI, 32'hFFFFFFFF);

      launch(3'd4, 32'd7, 32'd2, 1'b1);
      wait_done("divu", DC);

      launch(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_done("div_ovf", DC);
      chk("div_ovf_lo_const", LO, 32'h80000000);
      chk("div_ovf_hi_const", HI, 32'h00000000);

      MD_Op = 3'd5; D1 = 32'h12345678;
      step();
      chk("mthi_hi", HI, 32'h12345678);
      chk("mthi_busy", {31'd0, Busy}, 32'd0);
      MD_Op = 3'd6; D1 = 32'h9ABCDEF0;
      step();
      chk("mtlo_lo", LO, 32'h9ABCDEF0);
      chk("mtlo_hi_kept", HI, 32'h12345678);
      chk("mtlo_busy", {31'd0, Busy}, 32'd0);
      MD_Op = 3'd0;
      m_hi = 32'h12345678;
      m_lo = 32'h9ABCDEF0;

      launch(3'd4, 32'd99, 32'd0, 1'b1);
      wait_done("divu_by0", DC);
      launch(3'd3, 32'hFFFFFF00, 32'd0, 1'b1);
      wait_done("div_by0", DC);

      Start = 1'b1; MD_Op = 3'd0; D1 = 32'd5; D2 = 32'd6;
      step();
      Start = 1'b0;
      chk("start_none_busy", {31'd0, Busy}, 32'd0);

      launch(3'd1, 32'd1000, 32'hFFFFFFFF, 1'b1);
      Start = 1'b1; MD_Op = 3'd6; D1 = 32'hDEADBEEF;
      step();
      MD_Op = 3'd3; D1 = 32'd50; D2 = 32'd5;
      step();
      Start = 1'b0; MD_Op = 3'd0;
      wait_done("mult_ignore", MC - 2);
      step();
      chk("ignore_no_restart", {31'd0, Busy}, 32'd0);

      launch(3'd3, 32'd1000, 32'd3, 1'b0);
      step(); step(); step();
      #3 reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 2) step();
      chk("abort_busy_after", {31'd0, Busy}, 32'd0);
      chk("abort_hi_after", HI, 32'd0);
      chk("abort_lo_after", LO, 32'd0);

      launch(3'd1, 32'h00010000, 32'h00010000, 1'b1);
      wait_done("b2b_mult", MC);
      launch(3'd3, 32'd100, 32'd7, 1'b1);
      wait_done("b2b_div", DC);
      chk("b2b_lo_const", LO, 32'd14);
      chk("b2b_hi_const", HI, 32'd2);

      for (int i = 0; i < 6; i++) begin
         logic [2:0] op;
         op = 3'(1 + (i % 4));
         launch(op, $urandom, (i == 5) ? 32'($urandom_range(1, 9)) : $urandom, 1'b1);
         wait_done("rand", (op < 3'd3) ? MC : DC);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1);
   end

endmodule
